// File: rtl/sigma_xbus_arb.sv
// Two-master / one-slave MemSplit32 arbiter. Round-robin grant with an in-order
// read-ID FIFO that routes each read response to the master that issued it.
module sigma_xbus_arb #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                                 clk_i,
  input  logic                                 arst_n_i,
  // master 0 (CPU tile external port)
  input  logic                                 m0_req_i,
  input  logic                                 m0_we_i,
  input  logic [ADDR_W-1:0]                    m0_addr_bi,
  input  logic [DATA_W/8-1:0]                  m0_be_bi,
  input  logic [DATA_W-1:0]                    m0_wdata_bi,
  output logic                                 m0_ack_o,
  output logic                                 m0_resp_o,
  output logic [DATA_W-1:0]                    m0_rdata_bo,
  // master 1 (UDM host port)
  input  logic                                 m1_req_i,
  input  logic                                 m1_we_i,
  input  logic [ADDR_W-1:0]                    m1_addr_bi,
  input  logic [DATA_W/8-1:0]                  m1_be_bi,
  input  logic [DATA_W-1:0]                    m1_wdata_bi,
  output logic                                 m1_ack_o,
  output logic                                 m1_resp_o,
  output logic [DATA_W-1:0]                    m1_rdata_bo,
  // slave
  output logic                                 s_req_o,
  output logic                                 s_we_o,
  output logic [ADDR_W-1:0]                    s_addr_bo,
  output logic [DATA_W/8-1:0]                  s_be_bo,
  output logic [DATA_W-1:0]                    s_wdata_bo,
  input  logic                                 s_ack_i,
  input  logic                                 s_resp_i,
  input  logic [DATA_W-1:0]                    s_rdata_bi,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic                       rr_q, rr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
  logic                       err_q, err_d;

  logic fifo_full, fifo_empty;
  logic elig0, elig1, gnt;
  logic accept, push, pop, resp_vld, head_id;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first where needed) so no latch is inferred.
  always_comb begin
    fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty = (cnt_q == '0);

    // A read is held off while the ID FIFO is full; writes never need a slot.
    elig0 = m0_req_i & (m0_we_i | ~fifo_full);
    elig1 = m1_req_i & (m1_we_i | ~fifo_full);
    gnt   = (elig0 & elig1) ? rr_q : elig1;

    s_req_o    = (elig0 | elig1) & arst_n_i;
    s_we_o     = gnt ? m1_we_i     : m0_we_i;
    s_addr_bo  = gnt ? m1_addr_bi  : m0_addr_bi;
    s_be_bo    = gnt ? m1_be_bi    : m0_be_bi;
    s_wdata_bo = gnt ? m1_wdata_bi : m0_wdata_bi;

    accept   = s_req_o & s_ack_i;
    m0_ack_o = accept & ~gnt;
    m1_ack_o = accept & gnt;

    push     = accept & ~s_we_o;
    pop      = s_resp_i & ~fifo_empty;
    resp_vld = pop & arst_n_i;
    head_id  = id_fifo_q[rd_ptr_q];

    m0_resp_o   = resp_vld & ~head_id;
    m1_resp_o   = resp_vld & head_id;
    m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

    rr_d     = accept ? ~gnt : rr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    id_fifo_d = id_fifo_q;
    if (push) id_fifo_d[wr_ptr_q] = gnt;

    // A response with nothing outstanding is dropped and flagged until reset.
    err_d = err_q | (s_resp_i & fifo_empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the ID storage is deliberately not reset; an entry is only read
  // while the occupancy count marks it valid, and the count is reset.
  always_ff @(posedge clk_i) begin
    id_fifo_q <= id_fifo_d;
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sigma_xbus_arb.sv
// Self-checking bench for sigma_xbus_arb: the bench plays the slave, queues the
// expected response owner at each read accept and checks routing on every response.
module tb_sigma_xbus_arb;

  localparam int MAXO   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(MAXO + 1);

  logic                clk_i = 1'b0;
  logic                arst_n_i = 1'b0;
  logic                m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [ADDR_W-1:0]   m0_addr_bi, m1_addr_bi;
  logic [DATA_W/8-1:0] m0_be_bi, m1_be_bi;
  logic [DATA_W-1:0]   m0_wdata_bi, m1_wdata_bi;
  logic                m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [DATA_W-1:0]   m0_rdata_bo, m1_rdata_bo;
  logic                s_req_o, s_we_o, s_ack_i, s_resp_i;
  logic [ADDR_W-1:0]   s_addr_bo;
  logic [DATA_W/8-1:0] s_be_bo;
  logic [DATA_W-1:0]   s_wdata_bo, s_rdata_bi;
  logic [CNT_W-1:0]    outstanding_o;
  logic                err_o;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   exp_cnt = 0;
  logic exp_err = 1'b0;

  always #5 clk_i = ~clk_i;

  sigma_xbus_arb #(.MAX_OUTSTANDING(MAXO), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
    .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_bi = '0; m0_be_bi = 4'hF; m0_wdata_bi = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_bi = '0; m1_be_bi = 4'hF; m1_wdata_bi = '0;
    s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_bi = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks this cycle,
  // updates the scoreboard, and returns at the next falling edge.
  task automatic observe(input string tag, input logic e0, input logic e1);
    logic id;
    #1;
    check({tag, ".ack0"}, m0_ack_o, e0);
    check({tag, ".ack1"}, m1_ack_o, e1);
    check({tag, ".one_ack"}, m0_ack_o & m1_ack_o, 1'b0);
    check({tag, ".cnt"}, outstanding_o, exp_cnt);
    check({tag, ".err"}, err_o, exp_err);
    if (s_resp_i && exp_q.size() != 0) begin
      id = exp_q.pop_front();
      check({tag, ".resp0"}, m0_resp_o, !id);
      check({tag, ".resp1"}, m1_resp_o, id);
      check({tag, ".rdata0"}, m0_rdata_bo, id ? '0 : s_rdata_bi);
      check({tag, ".rdata1"}, m1_rdata_bo, id ? s_rdata_bi : '0);
      exp_cnt--;
    end else begin
      check({tag, ".noresp0"}, m0_resp_o, 1'b0);
      check({tag, ".noresp1"}, m1_resp_o, 1'b0);
      if (s_resp_i) exp_err = 1'b1;
    end
    if (e0 && !m0_we_i) begin exp_q.push_back(1'b0); exp_cnt++; end
    if (e1 && !m1_we_i) begin exp_q.push_back(1'b1); exp_cnt++; end
    @(negedge clk_i);
  endtask

  // Asserts reset with busy inputs, checks the quiet outputs, then releases.
  task automatic do_reset();
    arst_n_i = 1'b0;
    m0_req_i = 1'b1; m1_req_i = 1'b1; m0_we_i = 1'b0; m1_we_i = 1'b0;
    s_ack_i = 1'b1; s_resp_i = 1'b1; s_rdata_bi = 32'hFFFF_FFFF;
    #1;
    check("rst.s_req", s_req_o, 1'b0);
    check("rst.acks", {m0_ack_o, m1_ack_o}, 2'b00);
    check("rst.resps", {m0_resp_o, m1_resp_o}, 2'b00);
    check("rst.rdata", {m0_rdata_bo, m1_rdata_bo}, 64'h0);
    check("rst.cnt", outstanding_o, 0);
    check("rst.err", err_o, 1'b0);
    exp_q.delete(); exp_cnt = 0; exp_err = 1'b0;
    @(negedge clk_i);
    idle();
    arst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    @(negedge clk_i);
    do_reset();

    // Single master read, response two cycles after accept.
    m0_req_i = 1'b1; m0_addr_bi = 32'h8000_0004; s_ack_i = 1'b1;
    #1 check("t1.addr", s_addr_bo, 32'h8000_0004);
    observe("t1.c0", 1'b1, 1'b0);
    idle();
    observe("t1.c1", 1'b0, 1'b0);
    s_resp_i = 1'b1; s_rdata_bi = 32'h0000_00A5;
    observe("t1.c2", 1'b0, 1'b0);
    idle();
    observe("t1.c3", 1'b0, 1'b0);

    // Contention: continuous writes from both, grants alternate from m0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_bi = 32'h8000_0000; m0_wdata_bi = 32'h1000_0000 + i;
      m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_bi = 32'h8000_0000; m1_wdata_bi = 32'h2000_0000 + i;
      s_ack_i = 1'b1;
      #1 check("t2.wdata", s_wdata_bo, (i % 2 == 0) ? 32'h1000_0000 + i : 32'h2000_0000 + i);
      observe("t2.rr", (i % 2) == 0, (i % 2) == 1);
    end
    idle();

    // Interleaved reads: m1 then m0, in-order responses three cycles later.
    m1_req_i = 1'b1; m1_addr_bi = 32'h8000_0010; s_ack_i = 1'b1;
    observe("t3.c0", 1'b0, 1'b1);
    idle();
    m0_req_i = 1'b1; m0_addr_bi = 32'h8000_0020; s_ack_i = 1'b1;
    observe("t3.c1", 1'b1, 1'b0);
    idle();
    #1 check("t3.peak", outstanding_o, 2);
    observe("t3.c2", 1'b0, 1'b0);
    s_resp_i = 1'b1; s_rdata_bi = 32'h11;
    observe("t3.c3", 1'b0, 1'b0);
    s_rdata_bi = 32'h22;
    observe("t3.c4", 1'b0, 1'b0);
    idle();

    // FIFO full: four reads accepted, fifth held until a response frees a slot.
    for (int i = 0; i < 4; i++) begin
      m0_req_i = 1'b1; m0_addr_bi = 32'h8000_0100 + 4 * i; s_ack_i = 1'b1;
      observe("t4.fill", 1'b1, 1'b0);
    end
    m0_addr_bi = 32'h8000_0200;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_bi = 32'h8000_0300;
    observe("t4.full_w", 1'b0, 1'b1);
    m1_req_i = 1'b0; m1_we_i = 1'b0;
    #1 check("t4.sreq_blocked", s_req_o, 1'b0);
    observe("t4.held", 1'b0, 1'b0);
    s_resp_i = 1'b1; s_rdata_bi = 32'h33;
    observe("t4.pop", 1'b0, 1'b0);
    s_resp_i = 1'b0;
    observe("t4.fifth", 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      s_resp_i = 1'b1; s_rdata_bi = 32'h40 + i;
      observe("t4.drain", 1'b0, 1'b0);
    end
    idle();
    observe("t4.empty", 1'b0, 1'b0);

    // Spurious response with FIFO empty sets the sticky error.
    s_resp_i = 1'b1; s_rdata_bi = 32'hDEAD;
    observe("t5.spur", 1'b0, 1'b0);
    idle();
    observe("t5.sticky0", 1'b0, 1'b0);
    observe("t5.sticky1", 1'b0, 1'b0);
    do_reset();
    observe("t5.cleared", 1'b0, 1'b0);

    // Reset with two reads in flight; rr returns to m0, stale response flags error.
    m0_req_i = 1'b1; m0_addr_bi = 32'h8000_0400; s_ack_i = 1'b1;
    observe("t6.r0", 1'b1, 1'b0);
    observe("t6.r1", 1'b1, 1'b0);
    idle();
    observe("t6.inflight", 1'b0, 1'b0);
    do_reset();
    m0_req_i = 1'b1; m0_we_i = 1'b1; m1_req_i = 1'b1; m1_we_i = 1'b1; s_ack_i = 1'b1;
    observe("t6.rr0", 1'b1, 1'b0);
    idle();
    s_resp_i = 1'b1; s_rdata_bi = 32'hBEEF;
    observe("t6.stale", 1'b0, 1'b0);
    idle();
    observe("t6.err", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigma_xbus_arb.md
Name: sigma_xbus_arb

Overview:
- Two-master, one-slave arbiter for the MemSplit32 split-transaction bus.
- Lets the CPU tile external port (master 0) and the UDM host port (master 1) share one CSR/peripheral slave.
- Grants requests round-robin and tracks outstanding reads in an in-order ID FIFO, so every read response returns to the master that issued it.
- Sits between the sigma_tile xif / udm hif and the CSR decode logic at the sigma top level.

Parameters:
- MAX_OUTSTANDING, 4: depth of the read-ID FIFO, i.e. maximum accepted reads awaiting response; power of two, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- arst_n_i  in  1  asynchronous, active-low reset
- m0_req_i  in  1  master 0 request
- m0_we_i  in  1  master 0 write (1) / read (0)
- m0_addr_bi  in  ADDR_W  master 0 address
- m0_be_bi  in  DATA_W/8  master 0 byte enables
- m0_wdata_bi  in  DATA_W  master 0 write data
- m0_ack_o  out  1  master 0 request accepted
- m0_resp_o  out  1  master 0 read response valid
- m0_rdata_bo  out  DATA_W  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write/read
- s_addr_bo  out  ADDR_W  slave address
- s_be_bo  out  DATA_W/8  slave byte enables
- s_wdata_bo  out  DATA_W  slave write data
- s_ack_i  in  1  slave accepts request
- s_resp_i  in  1  slave read response valid
- s_rdata_bi  in  DATA_W  slave read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- err_o  out  1  sticky: response arrived with no read outstanding

Behaviour:
- Reset (arst_n_i=0, asynchronous): rr pointer=0 (master 0 preferred), FIFO empty, outstanding_o=0, err_o=0.
- Outputs during reset: all *_ack_o=0, *_resp_o=0, *_rdata_bo=0, s_req_o=0.
- Eligibility: master k is eligible when mk_req_i=1 AND (mk_we_i=1 OR FIFO not full).
  - Full is the registered count; a same-cycle pop does not unblock a read.
- Grant (combinational, same cycle):
  - Only one master eligible: that master is granted.
  - Both eligible: the master pointed to by rr is granted.
  - Neither eligible: s_req_o=0.
- Slave fields (s_we/addr/be/wdata) mux from the granted master; when no grant they are driven from master 0 and s_req_o=0.
- Ack routing: mk_ack_o = s_ack_i & s_req_o & grant==k. The ungranted master sees ack=0 and must hold its request stable.
- Accept event: s_req_o & s_ack_i.
  - On an accept, rr <= the other master.
  - Without an accept, rr holds.
- Read accept: push the granted master ID into the FIFO at the next edge.
- Writes push nothing and produce no response.
- Response: s_resp_i=1 with FIFO non-empty.
  - Route to the head ID: m(head)_resp_o=1, m(head)_rdata_bo=s_rdata_bi.
  - The other master sees resp=0, rdata=0. Combinational, zero latency.
  - Pop at the edge.
- Response with FIFO empty: dropped, no master sees resp, err_o <= 1 (sticky until reset).
- Simultaneous push and pop in one cycle: count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o = registered occupancy, range 0..MAX_OUTSTANDING.
- Latency: arbitration adds 0 cycles. Response ordering equals slave accept order.
- Reset mid-transaction: FIFO is cleared. Responses to pre-reset reads that arrive after reset set err_o; this is the required behaviour.
- Assertions for the bench: never both acks in one cycle; count never exceeds MAX_OUTSTANDING; resp only to the master holding the head ID.

Test Plan:
- Single master read: m0 read addr 0x80000004; slave acks at cycle 0 and returns 0x000000A5 two cycles later -> m0_ack_o at cycle 0, m0_resp_o=1 with rdata 0x000000A5, m1_resp_o=0, outstanding_o 1->0.
- Contention round-robin: m0 and m1 both hold continuous writes to 0x80000000, slave always acks -> grants alternate m0,m1,m0,m1 starting with m0 after reset; exactly one ack per cycle.
- Interleaved read routing: m1 read (resp 0x11), then m0 read (resp 0x22), slave responds in order after 3 cycles -> m1 receives 0x11, m0 receives 0x22; outstanding_o peaks at 2.
- FIFO full (MAX_OUTSTANDING=4): slave withholds responses; m0 issues 5 reads -> 4 acked, 5th held with ack=0, outstanding_o=4. m1 write during the full state is still acked. After one response the 5th read is acked the next cycle.
- Spurious response: s_resp_i=1 with FIFO empty -> no master resp, err_o=1 and stays 1 until arst_n_i asserted.
- Reset mid-flight: 2 reads outstanding, pulse arst_n_i low -> outstanding_o=0 and rr=0 immediately; a later stale response sets err_o=1.
